// File: rtl/uart_mem_loader.sv
// UART program loader: receives an A5-synced, checksummed word image over 8N1 serial
// and writes it into the unified memory, holding the CPU in reset until a good load completes.
module uart_mem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 3000,
  parameter int AW           = 12
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          uart_rx,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_error,
  output logic [2:0]    dbg_state,
  output logic [1:0]    dbg_rx_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {WAIT_SYNC, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR} ld_state_t;

  rx_state_t rx_state, rx_next;
  ld_state_t state, state_next;

  logic          rx_s1, rx_s2, rx_d;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_byte;
  logic          half_hit, bit_hit;
  // byte_valid / frame_err are single-cycle valid-only pulses with no ready: the loader
  // must act on them in the cycle they are high, and rx_byte holds until the next frame.
  logic          byte_valid, frame_err;

  logic [7:0]  cnt_lo, sum;
  logic [15:0] word_total, word_cnt, n_words;
  logic [1:0]  byte_idx;
  logic [23:0] shift;
  logic        last_word;

  assign half_hit = (clk_cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign bit_hit  = (clk_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_d && !rx_s2) rx_next = RX_START;
      RX_START: if (half_hit) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_hit && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (bit_hit) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_d       <= 1'b1;
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= uart_rx;
      rx_s2      <= rx_s1;
      rx_d       <= rx_s2;
      rx_state   <= rx_next;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
        end
        RX_START: clk_cnt <= half_hit ? '0 : clk_cnt + CW'(1);
        RX_DATA: begin
          if (bit_hit) begin
            clk_cnt <= '0;
            rx_byte <= {rx_s2, rx_byte[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (bit_hit) begin
            clk_cnt    <= '0;
            byte_valid <= rx_s2;
            frame_err  <= ~rx_s2;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: clk_cnt <= '0;
      endcase
    end
  end

  assign n_words   = {rx_byte, cnt_lo};
  assign last_word = (byte_idx == 2'd3) && (word_cnt + 16'd1 == word_total);

  always_comb begin
    state_next = state;
    if (frame_err && (state == CNT_LO || state == CNT_HI || state == DATA || state == CSUM)) begin
      state_next = ERR;
    end else if (byte_valid) begin
      case (state)
        WAIT_SYNC, DONE, ERR: if (rx_byte == 8'hA5) state_next = CNT_LO;
        CNT_LO: state_next = CNT_HI;
        CNT_HI: begin
          if (n_words > 16'(DEPTH))  state_next = ERR;
          else if (n_words == 16'd0) state_next = CSUM;
          else                       state_next = DATA;
        end
        DATA:    if (last_word) state_next = CSUM;
        CSUM:    state_next = (rx_byte == sum) ? DONE : ERR;
        default: state_next = WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= WAIT_SYNC;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cnt_lo     <= '0;
      word_total <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      shift      <= '0;
      sum        <= '0;
    end else begin
      state  <= state_next;
      mem_we <= 1'b0;
      if (mem_we) mem_addr <= mem_addr + AW'(1);
      if (byte_valid) begin
        case (state)
          WAIT_SYNC, DONE, ERR: begin
            if (rx_byte == 8'hA5) begin
              mem_addr <= '0;
              sum      <= '0;
              byte_idx <= '0;
              word_cnt <= '0;
            end
          end
          CNT_LO: cnt_lo     <= rx_byte;
          CNT_HI: word_total <= n_words;
          DATA: begin
            sum      <= sum + rx_byte;
            shift    <= {rx_byte, shift[23:8]};
            byte_idx <= byte_idx + 2'd1;
            // First byte of a word lands in bits 7:0 once all four have shifted in.
            if (byte_idx == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= {rx_byte, shift};
              word_cnt  <= word_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cpu_hold     = (state != DONE);
  assign load_done    = (state == DONE);
  assign load_error   = (state == ERR);
  assign dbg_state    = state;
  assign dbg_rx_state = rx_state;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: serial packets driven bit by bit, memory writes
// captured by a monitor and compared against hand-computed words and status flags.
module tb_uart_mem_loader;

  localparam int CPB = 8;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        uart_rx = 1'b1;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold, load_done, load_error;
  logic [2:0]  dbg_state;
  logic [1:0]  dbg_rx_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  pkt_q[$];
  logic [11:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] exp_q[$];

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .DEPTH(3000), .AW(12)) dut (
    .clk_in(clk_in), .reset(reset), .uart_rx(uart_rx),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
    .dbg_state(dbg_state), .dbg_rx_state(dbg_rx_state)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  // write monitor
  always @(negedge clk_in) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  // drivers (always entered on a falling clock edge)
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk_in);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk_in);
    uart_rx = 1'b1;
  endtask

  task automatic send_pkt();
    foreach (pkt_q[i]) send_byte(pkt_q[i], 1'b1);
  endtask

  task automatic clear_caps();
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold got %b want 1", cpu_hold); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done got %b want 0", load_done); end
    n_checks++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL reset_load_error got %b want 0", load_error); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    n_checks++; if (mem_addr !== 12'd0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 000", mem_addr); end
    n_checks++; if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    n_checks++; if (dbg_rx_state !== 2'd0) begin n_fail++; $display("FAIL reset_rx_state got %0d want 0", dbg_rx_state); end
  endtask

  task automatic test_load_two();
    clear_caps();
    pkt_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    exp_q = '{32'h12345678, 32'hDEADBEEF};
    send_pkt();
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL load2_done got %b want 1", load_done); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL load2_hold got %b want 0", cpu_hold); end
    n_checks++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL load2_error got %b want 0", load_error); end
    n_checks++; if (wr_data_q.size() != exp_q.size()) begin n_fail++; $display("FAIL load2_count got %0d want %0d", wr_data_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
      n_checks++; if (wr_addr_q[i] !== 12'(i)) begin n_fail++; $display("FAIL load2_addr[%0d] got %h want %h", i, wr_addr_q[i], 12'(i)); end
      n_checks++; if (wr_data_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL load2_data[%0d] got %h want %h", i, wr_data_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_bad_checksum();
    clear_caps();
    pkt_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4D};
    exp_q = '{32'h12345678, 32'hDEADBEEF};
    send_pkt();
    n_checks++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL badsum_error got %b want 1", load_error); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL badsum_hold got %b want 1", cpu_hold); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL badsum_done got %b want 0", load_done); end
    n_checks++; if (wr_data_q.size() != exp_q.size()) begin n_fail++; $display("FAIL badsum_count got %0d want %0d", wr_data_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
      n_checks++; if (wr_addr_q[i] !== 12'(i)) begin n_fail++; $display("FAIL badsum_addr[%0d] got %h want %h", i, wr_addr_q[i], 12'(i)); end
      n_checks++; if (wr_data_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL badsum_data[%0d] got %h want %h", i, wr_data_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_empty_oversize();
    clear_caps();
    pkt_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_pkt();
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL empty_done got %b want 1", load_done); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL empty_hold got %b want 0", cpu_hold); end
    n_checks++; if (wr_data_q.size() != 0) begin n_fail++; $display("FAIL empty_writes got %0d want 0", wr_data_q.size()); end
    clear_caps();
    pkt_q = '{8'hA5, 8'hB9, 8'h0B};
    send_pkt();
    n_checks++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL oversize_error got %b want 1", load_error); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL oversize_done got %b want 0", load_done); end
    n_checks++; if (wr_data_q.size() != 0) begin n_fail++; $display("FAIL oversize_writes got %0d want 0", wr_data_q.size()); end
  endtask

  task automatic test_sync_glitch();
    clear_caps();
    pkt_q = '{8'h11, 8'h22};
    send_pkt();
    uart_rx = 1'b0;
    repeat (2) @(negedge clk_in);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk_in);
    n_checks++; if (dbg_rx_state !== 2'd0) begin n_fail++; $display("FAIL glitch_rx_idle got %0d want 0", dbg_rx_state); end
    n_checks++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL junk_kept_error got %b want 1", load_error); end
    pkt_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    exp_q = '{32'h12345678, 32'hDEADBEEF};
    send_pkt();
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL sync_done got %b want 1", load_done); end
    n_checks++; if (wr_data_q.size() != exp_q.size()) begin n_fail++; $display("FAIL sync_count got %0d want %0d", wr_data_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
      n_checks++; if (wr_addr_q[i] !== 12'(i)) begin n_fail++; $display("FAIL sync_addr[%0d] got %h want %h", i, wr_addr_q[i], 12'(i)); end
      n_checks++; if (wr_data_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL sync_data[%0d] got %h want %h", i, wr_data_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_framing();
    clear_caps();
    pkt_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    send_pkt();
    send_byte(8'h33, 1'b0);
    repeat (2 * CPB) @(negedge clk_in);
    n_checks++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL frame_error got %b want 1", load_error); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL frame_hold got %b want 1", cpu_hold); end
    n_checks++; if (wr_data_q.size() != 0) begin n_fail++; $display("FAIL frame_writes got %0d want 0", wr_data_q.size()); end
    pkt_q = '{8'hA5, 8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h0A};
    exp_q = '{32'h01020304};
    send_pkt();
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL frame_recover_done got %b want 1", load_done); end
    n_checks++; if (wr_data_q.size() != exp_q.size()) begin n_fail++; $display("FAIL frame_recover_count got %0d want %0d", wr_data_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
      n_checks++; if (wr_addr_q[i] !== 12'(i)) begin n_fail++; $display("FAIL frame_recover_addr[%0d] got %h want %h", i, wr_addr_q[i], 12'(i)); end
      n_checks++; if (wr_data_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL frame_recover_data[%0d] got %h want %h", i, wr_data_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_load();
    clear_caps();
    pkt_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF};
    send_pkt();
    n_checks++; if (wr_data_q.size() != 1) begin n_fail++; $display("FAIL midrst_pre_count got %0d want 1", wr_data_q.size()); end
    n_checks++; if (mem_addr !== 12'd1) begin n_fail++; $display("FAIL midrst_pre_addr got %h want 001", mem_addr); end
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL midrst_state got %0d want 0", dbg_state); end
    n_checks++; if (mem_addr !== 12'd0) begin n_fail++; $display("FAIL midrst_addr got %h want 000", mem_addr); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL midrst_hold got %b want 1", cpu_hold); end
    clear_caps();
    pkt_q = '{8'hBE, 8'hAD, 8'hDE, 8'h4C};
    send_pkt();
    n_checks++; if (wr_data_q.size() != 0) begin n_fail++; $display("FAIL midrst_writes got %0d want 0", wr_data_q.size()); end
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL midrst_wait_sync got %0d want 0", dbg_state); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL midrst_hold2 got %b want 1", cpu_hold); end
    pkt_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    exp_q = '{32'h12345678, 32'hDEADBEEF};
    send_pkt();
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL midrst_reload_done got %b want 1", load_done); end
    n_checks++; if (wr_data_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midrst_reload_count got %0d want %0d", wr_data_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
      n_checks++; if (wr_addr_q[i] !== 12'(i)) begin n_fail++; $display("FAIL midrst_reload_addr[%0d] got %h want %h", i, wr_addr_q[i], 12'(i)); end
      n_checks++; if (wr_data_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_reload_data[%0d] got %h want %h", i, wr_data_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    @(negedge clk_in);
    test_reset();
    test_load_two();
    test_bad_checksum();
    test_empty_oversize();
    test_sync_glitch();
    test_framing();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
